// File: rtl/rf_arb_pkg.sv
// Shared types and default sizing for the register-file access arbiter.
package rf_arb_pkg;

  localparam int RF_DW           = 8;   // register data width
  localparam int RF_AW           = 5;   // register address width
  localparam int RF_NUM_REGS     = 32;  // registers swept by a clear
  localparam int RF_STARVE_LIMIT = 4;   // denied DBG cycles before a forced grant

  // Top-level sequencing: hardware clear sweep, or normal shared access.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  // Who drives the register-file port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // Fixed-priority pick with a starvation override for the debug requester.
  function automatic owner_e pick_owner(input logic starved,
                                        input logic cpu_req,
                                        input logic dbg_req);
    owner_e own;
    own = OWN_NONE;
    if (starved && dbg_req) begin
      own = OWN_DBG;
    end else if (cpu_req) begin
      own = OWN_CPU;
    end else if (dbg_req) begin
      own = OWN_DBG;
    end
    return own;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every register index after reset or on a clear
// command, and reports busy/done to the rest of the arbiter.
module rf_clear_seq
  import rf_arb_pkg::*;
#(
  parameter int AW       = RF_AW,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr_start,
  output logic          o_run,
  output logic          o_clr_busy,
  output logic          o_clr_done,
  output logic [AW-1:0] o_clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  arb_state_e    r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_clr_done;

  // Sweep FSM: CLEAR steps the index once per edge and hands over to RUN
  // after the last register; RUN re-enters CLEAR when a clear is requested.
  // A clear request during CLEAR is ignored so a sweep is never stretched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_idx  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state    <= ST_RUN;
            r_clr_idx  <= '0;
            r_clr_done <= 1'b1;
          end else begin
            r_clr_idx  <= r_clr_idx + IDX_ONE;
            r_clr_done <= 1'b0;
          end
        end
        ST_RUN: begin
          r_clr_done <= 1'b0;
          r_clr_idx  <= '0;
          if (i_clr_start) begin
            r_state <= ST_CLEAR;
          end
        end
        default: begin
          r_state    <= ST_CLEAR;
          r_clr_idx  <= '0;
          r_clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_run      = (r_state == ST_RUN);
  assign o_clr_busy = (r_state == ST_CLEAR);
  assign o_clr_done = r_clr_done;
  assign o_clr_idx  = r_clr_idx;

endmodule

// File: rtl/rf_access_arbiter.sv
// Register-file access arbiter: shares the single write/X port and the Y
// read port between the CPU and a debug/loader requester, and clears every
// register in hardware after reset or on command.
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW           = RF_DW,
  parameter int AW           = RF_AW,
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic          CLK,
  input  logic          RST_N,
  // clear control
  input  logic          CLR_START,
  output logic          CLR_BUSY,
  output logic          CLR_DONE,
  // CPU requester
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDRX,
  input  logic [AW-1:0] CPU_ADDRY,
  input  logic [DW-1:0] CPU_DIN,
  output logic          CPU_GNT,
  output logic [DW-1:0] CPU_DX,
  output logic [DW-1:0] CPU_DY,
  // debug/loader requester
  input  logic          DBG_REQ,
  input  logic          DBG_WE,
  input  logic [AW-1:0] DBG_ADDR,
  input  logic [DW-1:0] DBG_DIN,
  output logic          DBG_GNT,
  output logic [DW-1:0] DBG_DOUT,
  // register file side
  output logic [AW-1:0] RF_ADDRX,
  output logic [AW-1:0] RF_ADDRY,
  output logic          RF_WR,
  output logic [DW-1:0] RF_DIN,
  input  logic [DW-1:0] RF_DX_OUT,
  input  logic [DW-1:0] RF_DY_OUT
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic          w_run;
  logic [AW-1:0] w_clr_idx;
  logic          w_starved;
  owner_e        w_owner;
  logic [AW-1:0] w_addrx;
  logic [AW-1:0] w_addry;
  logic [DW-1:0] w_din;
  logic          w_wr;
  logic [3:0]    r_starve_cnt;

  rf_clear_seq #(
    .AW       (AW),
    .NUM_REGS (NUM_REGS)
  ) u_clear_seq (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_clr_start (CLR_START),
    .o_run       (w_run),
    .o_clr_busy  (CLR_BUSY),
    .o_clr_done  (CLR_DONE),
    .o_clr_idx   (w_clr_idx)
  );

  assign w_starved = (r_starve_cnt == STARVE_MAX);

  // Same-cycle arbitration; nobody is granted while the clear sweep owns the port.
  always_comb begin
    w_owner = OWN_NONE;
    if (w_run) begin
      w_owner = pick_owner(w_starved, CPU_REQ, DBG_REQ);
    end
  end

  assign CPU_GNT = (w_owner == OWN_CPU);
  assign DBG_GNT = (w_owner == OWN_DBG);

  // Port mux: the sweep writes zeros, otherwise the owner drives the pins and
  // an idle port parks on the CPU addresses with writes disabled.
  always_comb begin
    w_addrx = CPU_ADDRX;
    w_addry = CPU_ADDRY;
    w_din   = CPU_DIN;
    w_wr    = 1'b0;
    if (!w_run) begin
      w_addrx = w_clr_idx;
      w_din   = '0;
      w_wr    = 1'b1;
    end else begin
      case (w_owner)
        OWN_CPU: begin
          w_wr = CPU_WE;
        end
        OWN_DBG: begin
          w_addrx = DBG_ADDR;
          w_addry = DBG_ADDR;
          w_din   = DBG_DIN;
          w_wr    = DBG_WE;
        end
        default: begin
          w_wr = 1'b0;
        end
      endcase
    end
  end

  assign RF_ADDRX = w_addrx;
  assign RF_ADDRY = w_addry;
  assign RF_DIN   = w_din;
  // Reset gates the write strobe directly so an interrupted sweep stops at once.
  assign RF_WR    = w_wr & RST_N;

  assign CPU_DX   = RF_DX_OUT;
  assign CPU_DY   = RF_DY_OUT;
  assign DBG_DOUT = RF_DX_OUT;

  // Starvation counter: counts consecutive denied debug cycles in RUN,
  // saturating at the limit; frozen while a clear sweep runs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_starve_cnt <= 4'd0;
    end else if (w_run) begin
      if (DBG_REQ && !DBG_GNT) begin
        if (r_starve_cnt != STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
Sequences and shares the 32x8 register file's single write/X-address port and its Y read port between the CPU control path and a debug/loader requester. It also hardware-clears every register after reset and on command; the register file's own zero-init exists only in simulation. It sits between the control unit/debug UART and the register file and drives all register-file address and write inputs.

Parameters:
DW, 8, data width
AW, 5, register address width
NUM_REGS, 32, registers swept by clear (2**AW)
STARVE_LIMIT, 4, consecutive denied DBG cycles before DBG is forced a grant (1..15)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous reset, active low
CLR_START  in  1  start clear sweep (sampled in RUN only)
CLR_BUSY  out  1  clear sweep in progress
CLR_DONE  out  1  one-cycle pulse, sweep complete
CPU_REQ  in  1  CPU wants port this cycle
CPU_WE  in  1  CPU write enable
CPU_ADDRX  in  AW  CPU X address (write/read)
CPU_ADDRY  in  AW  CPU Y address (read)
CPU_DIN  in  DW  CPU write data
CPU_GNT  out  1  CPU owns port this cycle
CPU_DX  out  DW  X read data to CPU
CPU_DY  out  DW  Y read data to CPU
DBG_REQ  in  1  debug request
DBG_WE  in  1  debug write enable
DBG_ADDR  in  AW  debug address
DBG_DIN  in  DW  debug write data
DBG_GNT  out  1  debug owns port this cycle
DBG_DOUT  out  DW  debug read data
RF_ADDRX  out  AW  to register file X/write address
RF_ADDRY  out  AW  to register file Y address
RF_WR  out  1  to register file write enable
RF_DIN  out  DW  to register file write data
RF_DX_OUT  in  DW  register file X read data
RF_DY_OUT  in  DW  register file Y read data

Behaviour:
- States: CLEAR, RUN. Registers: state, clr_idx[AW-1:0], starve_cnt[3:0], CLR_DONE flop.
- Reset (RST_N low, async): state=CLEAR, clr_idx=0, starve_cnt=0, CLR_DONE=0. While RST_N low: RF_WR=0 (gated combinationally), CPU_GNT=DBG_GNT=0, CLR_BUSY=1.
- CLEAR: each cycle RF_ADDRX=clr_idx, RF_DIN=0, RF_WR=1, CLR_BUSY=1, no grants. clr_idx increments each edge. The first edge after reset release writes reg 0. After the edge writing NUM_REGS-1, state goes to RUN, clr_idx=0, and CLR_DONE=1 for exactly that next cycle. A sweep takes NUM_REGS cycles.
- CLR_START in CLEAR is ignored (no restart). CLR_START high in RUN causes CLEAR on the next edge. Grants in that sampling cycle still proceed normally.
- RUN grant rule (combinational, same cycle):
  - If starve_cnt==STARVE_LIMIT and DBG_REQ: DBG_GNT=1.
  - Else if CPU_REQ: CPU_GNT=1.
  - Else if DBG_REQ: DBG_GNT=1.
  - Never both grants at once.
- Port mux:
  - CPU granted: RF_ADDRX=CPU_ADDRX, RF_ADDRY=CPU_ADDRY, RF_DIN=CPU_DIN, RF_WR=CPU_WE.
  - DBG granted: RF_ADDRX=RF_ADDRY=DBG_ADDR, RF_DIN=DBG_DIN, RF_WR=DBG_WE.
  - No grant: CPU addresses/data on RF pins, RF_WR=0.
- Read returns: CPU_DX=RF_DX_OUT and CPU_DY=RF_DY_OUT always (valid when CPU_GNT). DBG_DOUT=RF_DX_OUT (valid when DBG_GNT). Read data is combinational; writes land at the granting edge.
- starve_cnt (RUN only):
  - Increments, saturating at STARVE_LIMIT, when DBG_REQ && !DBG_GNT.
  - Clears to 0 on DBG_GNT or !DBG_REQ.
  - Holds during CLEAR.
- Handshake: requesters hold REQ/address/data stable until GNT is seen high. One access per granted cycle; REQ held high requests further accesses.

Decomposition:
- Package rf_arb_pkg: state enum (CLEAR, RUN), DW/AW/NUM_REGS constants, owner enum (NONE, CPU, DBG) used by the mux.
- One natural sub-module: rf_clear_seq (clr_idx counter, CLR_BUSY, CLR_DONE, CLR_START handling). Arbitration and mux stay in the top level.

Test Plan:
- Release RST_N → RF_WR=1 for exactly 32 cycles with RF_ADDRX=0..31 and RF_DIN=0, CLR_DONE pulses once, then CLR_BUSY=0; requests during the sweep see no GNT.
- RUN, CPU_REQ=1 WE=1 ADDRX=5 DIN=0xA7, then a read of X=5/Y=5 → CPU_GNT=1 both cycles, CPU_DX=CPU_DY=0xA7.
- CPU_REQ and DBG_REQ held high with STARVE_LIMIT=4 → CPU granted for 4 cycles, DBG on the 5th, and the pattern repeats; never both grants.
- DBG write 0x3C to reg 31, then DBG read of reg 31 with CPU idle → DBG_GNT=1 same cycle, DBG_DOUT=0x3C.
- CLR_START in RUN after writing 0xFF to reg 10 → a 32-cycle sweep follows and a CPU read of reg 10 returns 0x00. A second CLR_START mid-sweep does not extend it (still 32 writes).
- Assert RST_N low mid-sweep at clr_idx=17 → RF_WR drops immediately. After release the sweep restarts at reg 0 and a full 32-write sweep runs.
